// File: rtl/charmap_scroll_if.sv
// charmap_scroll_if: read bus between the character-map generator and its char RAM, colour RAM and char ROM
//   map_addr  generator -> RAMs  {row,col} cell address
//   code_in   RAMs -> generator  character code, 1 clk after map_addr
//   color_in  RAMs -> generator  colour byte, 1 clk after map_addr
//   rom_addr  generator -> ROM   {code,line} glyph row address
//   glyph_in  ROM -> generator   glyph row, 1 clk after rom_addr
interface charmap_scroll_if #(
    parameter int COLS_LOG2   = 6,
    parameter int ROWS_LOG2   = 5,
    parameter int CODE_W      = 8,
    parameter int CHAR_H_LOG2 = 3
);
    logic [COLS_LOG2+ROWS_LOG2-1:0] map_addr;
    logic [CODE_W-1:0]              code_in;
    logic [7:0]                     color_in;
    logic [CODE_W+CHAR_H_LOG2-1:0]  rom_addr;
    logic [7:0]                     glyph_in;
    modport master (output map_addr, rom_addr, input code_in, color_in, glyph_in);
    modport slave  (input map_addr, rom_addr, output code_in, color_in, glyph_in);
endinterface

// File: rtl/charmap_scroll.sv
// charmap_scroll: character-map video generator with hardware scroll and background colour
//   clk_sys, reset          system clock, asynchronous active-high reset
//   ce_pix                  pixel clock enable
//   line_start, frame_start ce_pix-qualified timing strobes (frame_start latches scroll)
//   de, vcnt                display enable and current line number
//   scroll_x, scroll_y      pixel scroll offsets
//   bg_color                colour of glyph-0 pixels
//   mem                     char/colour RAM and char ROM read bus (master side)
//   VGA_R/G/B               registered pixel colour
module charmap_scroll #(
    parameter int COLS_LOG2   = 6,
    parameter int ROWS_LOG2   = 5,
    parameter int CODE_W      = 8,
    parameter int CHAR_H_LOG2 = 3
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ce_pix,
    input  logic                   line_start,
    input  logic                   frame_start,
    input  logic                   de,
    input  logic [8:0]             vcnt,
    input  logic [8:0]             scroll_x,
    input  logic [8:0]             scroll_y,
    input  logic [7:0]             bg_color,
    charmap_scroll_if.master       mem,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B
);
    typedef enum logic [2:0] {IDLE, MAP, CODE, ROM, CAPT} state_t;
    state_t state, state_nx;
    logic [8:0] sx, sy, sx_eff, sy_eff, px, px_cur, vy;
    logic [7:0] shift, next_glyph, next_color, cur_color, pix_c;
    logic [ROWS_LOG2-1:0] row;
    logic [CHAR_H_LOG2-1:0] line, line_q;
    logic [COLS_LOG2-1:0] col;
    logic fs, ls, trig, cap_code, cap_glyph, active, on, unused_vy;
    // A frame_start on this ce_pix overrides the latched scroll so line setup sees the new values
    assign fs = ce_pix & frame_start;
    assign ls = ce_pix & line_start;
    assign sx_eff = fs ? scroll_x : sx;
    assign sy_eff = fs ? scroll_y : sy;
    assign px_cur = ls ? sx_eff - 9'd16 : px;
    assign vy = vcnt + sy_eff;
    assign row = vy[CHAR_H_LOG2+ROWS_LOG2-1:CHAR_H_LOG2];
    assign line = vy[CHAR_H_LOG2-1:0];
    assign unused_vy = ^vy;
    // Prefetch the cell after the one containing px so it is ready at the next px[2:0]==7 load
    assign col = COLS_LOG2'(px_cur[8:3]) + COLS_LOG2'(1);
    assign trig = ce_pix & (px_cur[2:0] == 3'd0);
    assign pix_c = shift[7] ? cur_color : bg_color;
    assign on = de & active;
    always_comb begin
        state_nx = trig ? MAP : (state == MAP) ? CODE : (state == CODE) ? ROM : (state == ROM) ? CAPT : IDLE;
        cap_code = (state == CODE) & ~trig;
        cap_glyph = (state == CAPT) & ~trig;
    end
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sx <= '0;
            sy <= '0;
            px <= '0;
            shift <= '0;
            next_glyph <= '0;
            next_color <= '0;
            cur_color <= '0;
            line_q <= '0;
            active <= 1'b0;
            mem.map_addr <= '0;
            mem.rom_addr <= '0;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            state <= state_nx;
            if (trig) begin
                mem.map_addr <= {row, col};
                line_q <= line;
            end
            if (cap_code) begin
                next_color <= mem.color_in;
                mem.rom_addr <= {mem.code_in, line_q};
            end
            if (cap_glyph)
                next_glyph <= mem.glyph_in;
            if (ce_pix) begin
                if (fs) begin
                    sx <= scroll_x;
                    sy <= scroll_y;
                end
                // Output stays black after reset until a line has actually been set up
                if (ls)
                    active <= 1'b1;
                px <= px_cur + 9'd1;
                shift <= (px_cur[2:0] == 3'd7) ? next_glyph : {shift[6:0], 1'b0};
                cur_color <= (px_cur[2:0] == 3'd7) ? next_color : cur_color;
                VGA_R <= on ? {pix_c[2:0], pix_c[2:0], 2'b0} : 8'd0;
                VGA_G <= on ? {pix_c[5:3], pix_c[5:3], 2'b0} : 8'd0;
                VGA_B <= on ? {pix_c[7:6], pix_c[7:6], pix_c[7:6], 2'b0} : 8'd0;
            end
        end
    end
endmodule
